// File: rtl/datapath_register_bus.sv
// rtl/datapath_register_bus.sv - datapath register file with B_Bus read mux and memory/ALU taps
module datapath_register_bus #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             H_write,
  input  logic             W_write,
  input  logic             K_write,
  input  logic             Count_write,
  input  logic             X_write,
  input  logic             J_write,
  input  logic             L_write,
  input  logic             CenterP_write,
  input  logic             T_write,
  input  logic             AC_write,
  input  logic             PC_write,
  input  logic             MAR_write,
  input  logic             MDR_write,
  input  logic             IR_write,
  input  logic             DRAM_read,
  input  logic             H_read,
  input  logic             W_read,
  input  logic             K_read,
  input  logic             Count_read,
  input  logic             X_read,
  input  logic             J_read,
  input  logic             L_read,
  input  logic             CenterP_read,
  input  logic             T_read,
  input  logic             AC_read,
  input  logic             PC_read,
  input  logic             MDR_read,
  input  logic             MAR_read,
  input  logic             IR_read,
  input  logic             AC_reset,
  input  logic             PC_inc,
  input  logic [2:0]       mux_ctrl,
  input  logic [WIDTH-1:0] C_Bus,
  input  logic [WIDTH-1:0] FROM_DMEM,
  input  logic [WIDTH-1:0] FROM_IRAM,
  output logic [WIDTH-1:0] B_Bus,
  output logic [WIDTH-1:0] ALU_IN,
  output logic [WIDTH-1:0] TO_DMEM,
  output logic [WIDTH-1:0] DMEM_addr,
  output logic [WIDTH-1:0] IRAM_addr,
  output logic [WIDTH-1:0] MUX_out
);

  logic [WIDTH-1:0] h_q, w_q, k_q, count_q, x_q, j_q, l_q, centerp_q, t_q;
  logic [WIDTH-1:0] ac_q, pc_q, mdr_q, mar_q, ir_q;

  // General-purpose registers load straight from the ALU result bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q       <= '0;
      w_q       <= '0;
      k_q       <= '0;
      count_q   <= '0;
      x_q       <= '0;
      j_q       <= '0;
      l_q       <= '0;
      centerp_q <= '0;
      t_q       <= '0;
      mar_q     <= '0;
    end else begin
      if (H_write)       h_q       <= C_Bus;
      if (W_write)       w_q       <= C_Bus;
      if (K_write)       k_q       <= C_Bus;
      if (Count_write)   count_q   <= C_Bus;
      if (X_write)       x_q       <= C_Bus;
      if (J_write)       j_q       <= C_Bus;
      if (L_write)       l_q       <= C_Bus;
      if (CenterP_write) centerp_q <= C_Bus;
      if (T_write)       t_q       <= C_Bus;
      if (MAR_write)     mar_q     <= C_Bus;
    end
  end

  // Accumulator: synchronous clear wins over a load
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         ac_q <= '0;
    else if (AC_reset) ac_q <= '0;
    else if (AC_write) ac_q <= C_Bus;
  end

  // Program counter: explicit load wins over increment; increment wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         pc_q <= '0;
    else if (PC_write) pc_q <= C_Bus;
    else if (PC_inc)   pc_q <= pc_q + WIDTH'(1);
  end

  // Memory data register: a memory read wins over a load from the ALU
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          mdr_q <= '0;
    else if (DRAM_read) mdr_q <= FROM_DMEM;
    else if (MDR_write) mdr_q <= C_Bus;
  end

  // Instruction register only ever takes instruction-memory data
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         ir_q <= '0;
    else if (IR_write) ir_q <= FROM_IRAM;
  end

  // Operand bus: fixed-priority select, H highest, idle bus reads as zero
  always_comb begin
    B_Bus = '0;
    if      (H_read)       B_Bus = h_q;
    else if (W_read)       B_Bus = w_q;
    else if (K_read)       B_Bus = k_q;
    else if (Count_read)   B_Bus = count_q;
    else if (X_read)       B_Bus = x_q;
    else if (J_read)       B_Bus = j_q;
    else if (L_read)       B_Bus = l_q;
    else if (CenterP_read) B_Bus = centerp_q;
    else if (T_read)       B_Bus = t_q;
    else if (AC_read)      B_Bus = ac_q;
    else if (PC_read)      B_Bus = pc_q;
    else if (MDR_read)     B_Bus = mdr_q;
    else if (MAR_read)     B_Bus = mar_q;
    else if (IR_read)      B_Bus = ir_q;
  end

  // Observation mux for the datapath's internal buses and key registers
  always_comb begin
    MUX_out = '0;
    case (mux_ctrl)
      3'b000:  MUX_out = B_Bus;
      3'b001:  MUX_out = C_Bus;
      3'b010:  MUX_out = FROM_DMEM;
      3'b011:  MUX_out = mdr_q;
      3'b100:  MUX_out = ac_q;
      3'b101:  MUX_out = ir_q;
      default: MUX_out = '0;
    endcase
  end

  assign ALU_IN    = ac_q;
  assign TO_DMEM   = mdr_q;
  assign DMEM_addr = mar_q;
  assign IRAM_addr = pc_q;

endmodule

// File: tb/tb_datapath_register_bus.sv
// tb/tb_datapath_register_bus.sv - directed self-checking bench for datapath_register_bus
module tb_datapath_register_bus;

  logic        clk = 1'b0;
  logic        reset;
  logic        H_write, W_write, K_write, Count_write, X_write, J_write, L_write;
  logic        CenterP_write, T_write, AC_write, PC_write, MAR_write, MDR_write;
  logic        IR_write, DRAM_read;
  logic        H_read, W_read, K_read, Count_read, X_read, J_read, L_read;
  logic        CenterP_read, T_read, AC_read, PC_read, MDR_read, MAR_read, IR_read;
  logic        AC_reset, PC_inc;
  logic [2:0]  mux_ctrl;
  logic [23:0] C_Bus, FROM_DMEM, FROM_IRAM;
  logic [23:0] B_Bus, ALU_IN, TO_DMEM, DMEM_addr, IRAM_addr, MUX_out;

  int checks = 0;
  int fails  = 0;

  datapath_register_bus #(.WIDTH(24)) dut (
    .clk(clk), .reset(reset),
    .H_write(H_write), .W_write(W_write), .K_write(K_write), .Count_write(Count_write),
    .X_write(X_write), .J_write(J_write), .L_write(L_write), .CenterP_write(CenterP_write),
    .T_write(T_write), .AC_write(AC_write), .PC_write(PC_write), .MAR_write(MAR_write),
    .MDR_write(MDR_write), .IR_write(IR_write), .DRAM_read(DRAM_read),
    .H_read(H_read), .W_read(W_read), .K_read(K_read), .Count_read(Count_read),
    .X_read(X_read), .J_read(J_read), .L_read(L_read), .CenterP_read(CenterP_read),
    .T_read(T_read), .AC_read(AC_read), .PC_read(PC_read), .MDR_read(MDR_read),
    .MAR_read(MAR_read), .IR_read(IR_read), .AC_reset(AC_reset), .PC_inc(PC_inc),
    .mux_ctrl(mux_ctrl), .C_Bus(C_Bus), .FROM_DMEM(FROM_DMEM), .FROM_IRAM(FROM_IRAM),
    .B_Bus(B_Bus), .ALU_IN(ALU_IN), .TO_DMEM(TO_DMEM), .DMEM_addr(DMEM_addr),
    .IRAM_addr(IRAM_addr), .MUX_out(MUX_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle;
    {H_write, W_write, K_write, Count_write, X_write, J_write, L_write} = '0;
    {CenterP_write, T_write, AC_write, PC_write, MAR_write, MDR_write} = '0;
    {IR_write, DRAM_read, AC_reset, PC_inc} = '0;
    {H_read, W_read, K_read, Count_read, X_read, J_read, L_read} = '0;
    {CenterP_read, T_read, AC_read, PC_read, MDR_read, MAR_read, IR_read} = '0;
    mux_ctrl = 3'b000;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Load one general register from C_Bus, then read it back on B_Bus
  task automatic load_read(input int idx, input logic [23:0] val, input string tag);
    idle();
    C_Bus = val;
    case (idx)
      0: H_write = 1'b1;       1: W_write = 1'b1;     2: K_write = 1'b1;
      3: Count_write = 1'b1;   4: X_write = 1'b1;     5: J_write = 1'b1;
      6: L_write = 1'b1;       7: CenterP_write = 1'b1;
      default: T_write = 1'b1;
    endcase
    step();
    idle();
    C_Bus = 24'd0;
    case (idx)
      0: H_read = 1'b1;        1: W_read = 1'b1;      2: K_read = 1'b1;
      3: Count_read = 1'b1;    4: X_read = 1'b1;      5: J_read = 1'b1;
      6: L_read = 1'b1;        7: CenterP_read = 1'b1;
      default: T_read = 1'b1;
    endcase
    #1 check(tag, B_Bus, val);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bbus"}, B_Bus, 24'd0);
    check({tag, "_alu"},  ALU_IN, 24'd0);
    check({tag, "_todm"}, TO_DMEM, 24'd0);
    check({tag, "_dmad"}, DMEM_addr, 24'd0);
    check({tag, "_iram"}, IRAM_addr, 24'd0);
    check({tag, "_mux"},  MUX_out, 24'd0);
  endtask

  initial begin
    idle();
    C_Bus = '0; FROM_DMEM = '0; FROM_IRAM = '0;
    reset = 1'b1;
    #12;
    check_all_zero("reset");
    reset = 1'b0;
    step();
    check_all_zero("post_reset");

    load_read(0, 24'd32,   "H");
    load_read(8, 24'd256,  "T");
    load_read(5, 24'd16,   "J");
    load_read(6, 24'd160,  "L");
    load_read(1, 24'd1600, "W");
    load_read(4, 24'd100,  "X");
    load_read(7, 24'd101,  "CenterP");
    load_read(3, 24'd102,  "Count");
    load_read(2, 24'd32,   "K");

    // B_Bus shows pre-edge value while a write to the same register is pending
    idle(); H_read = 1'b1; H_write = 1'b1; C_Bus = 24'd77;
    #1 check("H_pre_edge", B_Bus, 24'd32);
    step();
    check("H_post_edge", B_Bus, 24'd77);
    idle(); C_Bus = 24'd32; H_write = 1'b1;
    step();

    // Accumulator
    idle(); C_Bus = 24'd32; AC_write = 1'b1;
    step();
    idle(); AC_read = 1'b1;
    #1 check("AC_alu_in", ALU_IN, 24'd32);
    check("AC_bbus", B_Bus, 24'd32);
    mux_ctrl = 3'b100;
    #1 check("AC_mux", MUX_out, 24'd32);
    idle(); C_Bus = 24'd55; AC_write = 1'b1; AC_reset = 1'b1;
    step();
    check("AC_reset_prio", ALU_IN, 24'd0);

    // Program counter
    idle(); C_Bus = 24'd4; PC_write = 1'b1;
    step();
    check("PC_load", IRAM_addr, 24'd4);
    idle(); PC_inc = 1'b1;
    step();
    step();
    check("PC_inc2", IRAM_addr, 24'd6);
    idle(); C_Bus = 24'hFFFFFF; PC_write = 1'b1;
    step();
    idle(); PC_inc = 1'b1;
    step();
    check("PC_wrap", IRAM_addr, 24'd0);
    idle(); C_Bus = 24'd9; PC_write = 1'b1; PC_inc = 1'b1;
    step();
    check("PC_write_prio", IRAM_addr, 24'd9);

    // MAR and IR
    idle(); C_Bus = 24'd11; MAR_write = 1'b1;
    step();
    check("MAR", DMEM_addr, 24'd11);
    idle(); FROM_IRAM = 24'd12; C_Bus = 24'd99; IR_write = 1'b1;
    step();
    idle(); IR_read = 1'b1;
    #1 check("IR_bbus", B_Bus, 24'd12);
    mux_ctrl = 3'b101;
    #1 check("IR_mux", MUX_out, 24'd12);

    // MDR
    idle(); C_Bus = 24'd3; MDR_write = 1'b1;
    step();
    check("MDR_write", TO_DMEM, 24'd3);
    idle(); DRAM_read = 1'b1; FROM_DMEM = 24'd1; MDR_write = 1'b1; C_Bus = 24'd7;
    step();
    check("MDR_dram_prio", TO_DMEM, 24'd1);
    idle(); MDR_read = 1'b1; mux_ctrl = 3'b000; C_Bus = 24'd7; FROM_DMEM = 24'd5;
    #1 check("MUX_bbus_mdr", MUX_out, 24'd1);
    mux_ctrl = 3'b001;
    #1 check("MUX_cbus", MUX_out, 24'd7);
    mux_ctrl = 3'b010;
    #1 check("MUX_dmem", MUX_out, 24'd5);
    mux_ctrl = 3'b011;
    #1 check("MUX_mdr", MUX_out, 24'd1);
    mux_ctrl = 3'b110;
    #1 check("MUX_110", MUX_out, 24'd0);
    mux_ctrl = 3'b111;
    #1 check("MUX_111", MUX_out, 24'd0);

    // Read priority and idle bus
    idle(); H_read = 1'b1; T_read = 1'b1;
    #1 check("prio_H_T", B_Bus, 24'd32);
    idle(); T_read = 1'b1; PC_read = 1'b1; IR_read = 1'b1;
    #1 check("prio_T_PC", B_Bus, 24'd256);
    idle(); PC_read = 1'b1; MAR_read = 1'b1;
    #1 check("prio_PC_MAR", B_Bus, 24'd9);
    idle();
    #1 check("no_read", B_Bus, 24'd0);

    // Asynchronous reset mid-cycle with writes pending
    idle(); C_Bus = 24'd44; H_write = 1'b1; PC_inc = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    H_read = 1'b1;
    #1 check_all_zero("mid_reset");
    H_read = 1'b0; T_read = 1'b1;
    #1 check("mid_reset_T", B_Bus, 24'd0);
    step();
    check("reset_hold_pc", IRAM_addr, 24'd0);
    reset = 1'b0;
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/datapath_register_bus.md
Name: datapath_register_bus

Overview:
- Register file plus bus interconnect for the processor datapath.
- Holds fourteen 24-bit registers: H, W, K, Count, X, J, L, CenterP, T, AC, PC, MDR, MAR, IR.
- Loads registers from the ALU result bus (C_Bus) or from memory, and drives one selected register onto the operand bus (B_Bus).
- Sources the instruction-memory address, data-memory address/data and the ALU accumulator input.

Parameters:
- WIDTH, 24, width of every register and every data bus.

Ports:
- clk  input  1  system clock; all register updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all registers.
- H_write, W_write, K_write, Count_write, X_write, J_write, L_write, CenterP_write, T_write, AC_write, PC_write, MAR_write  input  1 each  load the named register from C_Bus.
- MDR_write  input  1  load MDR from C_Bus.
- IR_write  input  1  load IR from FROM_IRAM.
- DRAM_read  input  1  load MDR from FROM_DMEM.
- H_read, W_read, K_read, Count_read, X_read, J_read, L_read, CenterP_read, T_read, AC_read, PC_read, MDR_read, MAR_read, IR_read  input  1 each  drive the named register onto B_Bus.
- AC_reset  input  1  synchronous clear of AC.
- PC_inc  input  1  increment PC by 1.
- mux_ctrl  input  3  MUX_out source select.
- C_Bus  input  WIDTH  ALU result bus.
- FROM_DMEM  input  WIDTH  data-memory read data.
- FROM_IRAM  input  WIDTH  instruction-memory read data.
- B_Bus  output  WIDTH  operand bus.
- ALU_IN  output  WIDTH  AC contents.
- TO_DMEM  output  WIDTH  MDR contents (data-memory write data).
- DMEM_addr  output  WIDTH  MAR contents.
- IRAM_addr  output  WIDTH  PC contents.
- MUX_out  output  WIDTH  mux_ctrl-selected value.

Behaviour:
- Reset: while reset is high, all 14 registers are 0 immediately, independent of clk. Consequently B_Bus, ALU_IN, TO_DMEM, DMEM_addr, IRAM_addr and MUX_out are all 0.
- Register writes happen on the rising clk edge. A value loaded at edge N is visible on the outputs right after edge N.
- Simple loads: each *_write loads its register from C_Bus. Multiple different registers may load on the same edge.
- AC: AC_reset has priority over AC_write and clears AC to 0.
- PC: PC_write has priority over PC_inc. PC_inc adds 1 per rising edge while held. Wrap-around: 24'hFFFFFF + 1 = 0.
- MDR: DRAM_read (loads FROM_DMEM) has priority over MDR_write (loads C_Bus).
- IR: loads FROM_IRAM only, on IR_write.
- No write strobe active: register holds its value.
- B_Bus is combinational with no latency; read strobes are not registered.
  - If several *_read are high, fixed priority decides: H, W, K, Count, X, J, L, CenterP, T, AC, PC, MDR, MAR, IR (H highest).
  - No read strobe high: B_Bus = 0.
  - Within a cycle, B_Bus shows the pre-edge register value; it updates after the edge.
- Fixed combinational outputs: ALU_IN = AC, TO_DMEM = MDR, DMEM_addr = MAR, IRAM_addr = PC.
- MUX_out is combinational, selected by mux_ctrl:
  - 000 = B_Bus
  - 001 = C_Bus
  - 010 = FROM_DMEM
  - 011 = MDR
  - 100 = AC
  - 101 = IR
  - 110, 111 = 0
- Unknown or undriven inputs are not sanitised; the design does not rely on them.
- Reset asserted mid-operation overrides any pending write or increment on the same edge.

Test Plan:
- Reset high, then low; all outputs 0. H_write=1, C_Bus=32, one edge; H_write=0, H_read=1 -> B_Bus=32. Repeat the pattern for T=256, J=16, L=160, W=1600, X=100, CenterP=101, Count=102, K=32 -> B_Bus equals the loaded value each time.
- AC_write with C_Bus=32 -> ALU_IN=32, and AC_read gives B_Bus=32. AC_write=1 and AC_reset=1 on the same edge -> AC=0.
- PC_write with C_Bus=4 -> IRAM_addr=4. PC_inc held 2 edges -> IRAM_addr=6. PC=24'hFFFFFF with PC_inc -> 0. PC_write=1, C_Bus=9, PC_inc=1 -> PC=9.
- MAR_write with C_Bus=11 -> DMEM_addr=11. FROM_IRAM=12 with IR_write -> IR_read gives B_Bus=12, and mux_ctrl=101 gives MUX_out=12.
- MDR_write with C_Bus=3 -> TO_DMEM=3. DRAM_read=1, FROM_DMEM=1, MDR_write=1, C_Bus=7 -> TO_DMEM=1. mux_ctrl=000 with MDR_read -> MUX_out=1.
- H=32 and T=256 loaded, H_read=T_read=1 -> B_Bus=32. No reads -> B_Bus=0. Reset pulsed mid-clock -> all registers 0 before the next edge.
